// File: rtl/jk_counter_if.sv
// Purpose: groups the control, data and status signals of the jk_counter bank into one bundle.
// Latency: none; this is wiring only.
// Backpressure: none; the bank accepts an operation on every enabled edge.
// Ports (master = controlling side, slave = counter bank):
//   en, mode, j, k, d   master -> slave   enable, operation select, JK inputs, load data
//   q, qb, tc, ovf      slave  -> master  state, complement, terminal count, sticky wrap flag
interface jk_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, j, k, d,
        input  q, qb, tc, ovf
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qb, tc, ovf
    );
endinterface

// File: rtl/jk_counter.sv
// Purpose: WIDTH-bit bank of JK flip-flops that also acts as a modulo up/down counter or load register.
// Latency: one clock from inputs to q/qb/ovf; tc is combinational from q and mode.
// Backpressure: none; en=0 holds all state, clr (sync, active-high) overrides everything.
// Ports:
//   clk   rising-edge clock
//   clr   synchronous active-high clear: q=0, qb=all ones, ovf=0
//   bus   jk_counter_if slave: en, mode(00 JK, 01 up, 10 down, 11 load), j, k, d in;
//         q, qb, tc, ovf out
module jk_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic          clk,
    input  logic          clr,
    jk_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (bus.en) begin
            case (mode)
                // Per-bit JK: set where j & ~q, keep where ~k & q.
                // Covers hold (00), set (10), clear (01) and toggle (11).
                MODE_JK: begin
                    q_d = (bus.j & ~q_q) | (~bus.k & q_q);
                end
                // Values above MAX_COUNT (reachable only by load or JK) also
                // wrap to zero rather than counting on up to all ones.
                MODE_UP: begin
                    if (q_q >= MAX_Q) begin
                        q_d   = '0;
                        ovf_d = 1'b1;
                    end else begin
                        q_d = q_q + ONE_Q;
                    end
                end
                // Out-of-range values simply count down toward MAX_COUNT.
                MODE_DOWN: begin
                    if (q_q == '0) begin
                        q_d   = MAX_Q;
                        ovf_d = 1'b1;
                    end else begin
                        q_d = q_q - ONE_Q;
                    end
                end
                MODE_LOAD: begin
                    q_d   = bus.d;
                    ovf_d = 1'b0;
                end
                default: begin
                    q_d   = q_q;
                    ovf_d = ovf_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // qb is a direct inversion of the register, so it is glitch-free and
    // can never disagree with q.
    assign bus.q   = q_q;
    assign bus.qb  = ~q_q;
    assign bus.ovf = ovf_q;

    // tc deliberately ignores en: it flags that the next enabled edge wraps.
    assign bus.tc  = ((mode == MODE_UP)   && (q_q >= MAX_Q)) ||
                     ((mode == MODE_DOWN) && (q_q == '0));

endmodule

// File: tb/tb_jk_counter.sv
module tb_jk_counter;

    localparam int W    = 4;
    localparam int MAXC = 9;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    jk_counter_if #(.WIDTH(W)) bus ();

    jk_counter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the count as a plain integer plus the wrap flag.
    int m_q   = 0;
    int m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic c, input logic e, input logic [1:0] m,
                              input logic [W-1:0] jj, input logic [W-1:0] kk,
                              input logic [W-1:0] dd);
        int bit_val;
        int nq;
        if (c) begin
            m_q   = 0;
            m_ovf = 0;
        end else if (e) begin
            case (m)
                2'd0: begin
                    nq = 0;
                    for (int i = 0; i < W; i++) begin
                        bit_val = (m_q / (2**i)) % 2;
                        if (jj[i] && kk[i])       bit_val = 1 - bit_val;
                        else if (jj[i])           bit_val = 1;
                        else if (kk[i])           bit_val = 0;
                        nq = nq + bit_val * (2**i);
                    end
                    m_q = nq;
                end
                2'd1: begin
                    if (m_q >= MAXC) begin m_q = 0; m_ovf = 1; end
                    else m_q = m_q + 1;
                end
                2'd2: begin
                    if (m_q == 0) begin m_q = MAXC; m_ovf = 1; end
                    else m_q = m_q - 1;
                end
                default: begin
                    m_q   = int'(dd);
                    m_ovf = 0;
                end
            endcase
        end
    endtask

    function automatic logic model_tc(input logic [1:0] m);
        return ((m == 2'd1) && (m_q >= MAXC)) || ((m == 2'd2) && (m_q == 0));
    endfunction

    // Apply one set of inputs across one rising edge and compare every output.
    task automatic step(input string tag, input logic c, input logic e, input logic [1:0] m,
                        input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] dd);
        clr      = c;
        bus.en   = e;
        bus.mode = m;
        bus.j    = jj;
        bus.k    = kk;
        bus.d    = dd;
        @(posedge clk);
        #1;
        model_edge(c, e, m, jj, kk, dd);
        check({tag, "_q"},   32'(bus.q),   32'(m_q));
        check({tag, "_qb"},  32'(bus.qb),  32'((~m_q) & ((1 << W) - 1)));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
        check({tag, "_tc"},  32'(bus.tc),  32'(model_tc(m)));
    endtask

    initial begin
        clr      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = 2'b00;
        bus.j    = '0;
        bus.k    = '0;
        bus.d    = '0;

        // Reset: establish arbitrary state, then clr must beat a load of 4'hA.
        step("init_clr", 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        step("ld7",      1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h7);
        step("ld7_up",   1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        step("clr_ld",   1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'hA);
        check("clr_q_const",  32'(bus.q),   32'h0);
        check("clr_qb_const", 32'(bus.qb),  32'hF);
        check("clr_ovf_const",32'(bus.ovf), 32'h0);

        // JK truth table from 0101.
        step("ld5",  1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h5);
        step("jk",   1'b0, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'h0);
        check("jk_q_const",  32'(bus.q),  32'hD);
        check("jk_qb_const", 32'(bus.qb), 32'h2);

        // Up wrap with MAX_COUNT = 9; tc must show while en is low.
        step("clr_up", 1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 9; i++) step("up", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("up9_q_const",  32'(bus.q),  32'd9);
        check("up9_tc_const", 32'(bus.tc), 32'd1);
        step("up_hold_tc", 1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);
        step("up_wrap",    1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        check("upwrap_ovf_const", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 3; i++) step("en_hold", 1'b0, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0);

        // Down wrap.
        step("ld1",    1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h1);
        step("dn_to0", 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        step("dn_wrap",1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        check("dnwrap_q_const", 32'(bus.q), 32'd9);
        step("ld3",    1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h3);

        // Out-of-range values.
        step("ld12a",  1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'hC);
        step("oor_up", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        step("ld12b",  1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'hC);
        step("oor_dn", 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        check("oordn_q_const", 32'(bus.q), 32'd11);

        // Mode switch mid-count, then clr during a down edge.
        step("ld4",   1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h4);
        step("ms_up1",1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        step("ms_up2",1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        step("ms_dn1",1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        check("msdn_q_const", 32'(bus.q), 32'd5);
        step("ms_clr",1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
